// File: rtl/arb_mux_pkg.sv
// Shared constants for the registered round-robin / fixed-select channel mux.
package arb_mux_pkg;

    // Values of the mode input.
    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Default parameter values.
    localparam int DEF_WIDTH      = 8;
    localparam int DEF_CHANNELS   = 4;
    localparam int DEF_SEL_LENGTH = 2;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: scans the request vector starting one
// past the last-served channel, wrapping at CHANNELS-1, and returns the first
// requester as a one-hot grant plus its encoded index.
module rr_arbiter
    import arb_mux_pkg::*;
#(
    parameter int CHANNELS   = DEF_CHANNELS,
    parameter int SEL_LENGTH = DEF_SEL_LENGTH
) (
    input  logic [CHANNELS-1:0]   req,
    input  logic [SEL_LENGTH-1:0] last,
    output logic [CHANNELS-1:0]   grant,
    output logic [SEL_LENGTH-1:0] grant_idx
);

    int  scan_idx;
    logic found;

    // Priority scan from last+1 upward; first requesting channel wins.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // so no path leaves a value unassigned and no latch is inferred.
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        scan_idx  = 0;
        for (int off = 1; off <= CHANNELS; off++) begin
            scan_idx = (int'(last) + off) % CHANNELS;
            if (!found && req[scan_idx]) begin
                found           = 1'b1;
                grant[scan_idx] = 1'b1;
                grant_idx       = SEL_LENGTH'(scan_idx);
            end
        end
    end

endmodule

// File: rtl/arb_mux_rr.sv
// Registered, flow-controlled channel multiplexer with fixed-select or
// round-robin arbitration and valid/ready handshakes on every channel.
// Optional build macro ARB_MUX_SKID_EN adds a skid entry behind the output
// register so in_ready no longer depends combinationally on out_ready.
module arb_mux_rr
    import arb_mux_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int CHANNELS   = DEF_CHANNELS,
    parameter int SEL_LENGTH = DEF_SEL_LENGTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS*WIDTH-1:0] in_bus,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic                      mode,
    input  logic [SEL_LENGTH-1:0]     sel,
    output logic [WIDTH-1:0]          out,
    output logic [SEL_LENGTH-1:0]     out_sel,
    output logic                      out_valid,
    input  logic                      out_ready
);

    logic [CHANNELS-1:0]   rr_grant;
    logic [SEL_LENGTH-1:0] rr_idx;
    logic [CHANNELS-1:0]   fix_grant;
    logic [CHANNELS-1:0]   grant;
    logic [SEL_LENGTH-1:0] grant_idx;
    logic [WIDTH-1:0]      acc_data;
    logic                  can_accept;
    logic                  accept;
    logic                  out_xfer;

    logic [SEL_LENGTH-1:0] last_q;
    logic [WIDTH-1:0]      out_q;
    logic [SEL_LENGTH-1:0] out_sel_q;
    logic                  out_valid_q;

    rr_arbiter #(
        .CHANNELS   (CHANNELS),
        .SEL_LENGTH (SEL_LENGTH)
    ) u_rr_arbiter (
        .req       (in_valid),
        .last      (last_q),
        .grant     (rr_grant),
        .grant_idx (rr_idx)
    );

    // Fixed-select grant; an out-of-range sel matches no channel.
    always_comb begin
        fix_grant = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (int'(sel) == i) fix_grant[i] = in_valid[i];
        end
    end

    // Mode mux between the two grant sources and the granted word.
    always_comb begin
        grant     = (mode == MODE_RR) ? rr_grant : fix_grant;
        grant_idx = (mode == MODE_RR) ? rr_idx   : sel;
        acc_data  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (grant[i]) acc_data = in_bus[i*WIDTH +: WIDTH];
        end
    end

    assign out_xfer = out_valid_q & out_ready;
    assign in_ready = (reset || !can_accept) ? '0 : grant;
    assign accept   = |in_ready;

    // Round-robin pointer advances only on an accepted input, in both modes.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset)       last_q <= SEL_LENGTH'(CHANNELS - 1);
        else if (accept) last_q <= grant_idx;
    end

`ifdef ARB_MUX_SKID_EN
    logic [WIDTH-1:0]      skid_q;
    logic [SEL_LENGTH-1:0] skid_sel_q;
    logic                  skid_valid_q;

    assign can_accept = ~skid_valid_q;

    // Output register plus skid entry; skid drains into output on a transfer.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_q        <= '0;
            out_sel_q    <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else if (skid_valid_q) begin
            if (out_xfer) begin
                out_q        <= skid_q;
                out_sel_q    <= skid_sel_q;
                skid_valid_q <= 1'b0;
            end
        end else if (accept) begin
            if (!out_valid_q || out_xfer) begin
                out_q       <= acc_data;
                out_sel_q   <= grant_idx;
                out_valid_q <= 1'b1;
            end else begin
                skid_valid_q <= 1'b1;
            end
        end else if (out_xfer) begin
            out_valid_q <= 1'b0;
        end
    end

    // Skid payload is qualified by skid_valid_q and never read while empty.
    always_ff @(posedge clk) begin
        // NOTE: data-only storage needs no reset; its valid flag guards it.
        if (accept && out_valid_q && !out_xfer) begin
            skid_q     <= acc_data;
            skid_sel_q <= grant_idx;
        end
    end
`else
    assign can_accept = ~out_valid_q | out_ready;

    // Single output register: load on accept, clear valid when drained.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_q       <= '0;
            out_sel_q   <= '0;
            out_valid_q <= 1'b0;
        end else if (accept) begin
            out_q       <= acc_data;
            out_sel_q   <= grant_idx;
            out_valid_q <= 1'b1;
        end else if (out_xfer) begin
            out_valid_q <= 1'b0;
        end
    end
`endif

    assign out       = out_q;
    assign out_sel   = out_sel_q;
    assign out_valid = out_valid_q;

endmodule
